// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined chunk adder.
//   ADD / SUB     : values of the 'sub' mode input
//   chunk_cfg_ok  : true when WIDTH is a positive multiple of CHUNK,
//                   used by the top level to reject bad parameter sets
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder: {Cout, s} = A + B + c.
//   A, B : slice operands (CHUNK bits)
//   c    : carry into the slice
//   s    : slice sum (CHUNK bits)
//   Cout : carry out of the slice
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             c,
  output logic [CHUNK-1:0] s,
  output logic             Cout
);

  logic [CHUNK:0] total;

  assign total     = {1'b0, A} + {1'b0, B} + {{CHUNK{1'b0}}, c};
  assign {Cout, s} = total;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit adder/subtractor built from STAGES = WIDTH/CHUNK
// slices, one registered slice per stage, with valid/ready handshaking.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready depends only on
//                           out_valid and out_ready)
//   X, Y, Cin, sub        : operands, carry-in (ADD only), mode (1 = X-Y)
//   out_valid / out_ready : result handshake
//   s                     : {carry_out, sum}; in SUB mode carry = NOT borrow
//   ovf                   : two's-complement overflow of the WIDTH-bit sum
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  logic adv;

  // Registers at the output of each stage. x/y are the skewed operands
  // (full width so the MSBs needed for overflow ride along), sum is the
  // deskewed result with slices 0..k filled in after stage k.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  x_d   [STAGES];
  logic [WIDTH-1:0]  y_q   [STAGES];
  logic [WIDTH-1:0]  y_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // What each stage sees on its input side: the ports for stage 0,
  // the previous stage's registers otherwise.
  logic [WIDTH-1:0]  x_in   [STAGES];
  logic [WIDTH-1:0]  y_in   [STAGES];
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] valid_in;

  logic [WIDTH-1:0]  chunk_a;
  logic [WIDTH-1:0]  chunk_b;
  logic [WIDTH-1:0]  chunk_s;
  logic [STAGES-1:0] chunk_co;

  // Every stage moves together; a held result blocks the whole pipe.
  assign adv       = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign s         = {carry_q[STAGES-1], sum_q[STAGES-1]};
  assign ovf       = (x_q[STAGES-1][WIDTH-1] == y_q[STAGES-1][WIDTH-1]) &&
                     (sum_q[STAGES-1][WIDTH-1] != x_q[STAGES-1][WIDTH-1]);

  // Subtraction is X + ~Y + 1, so the inversion and forced carry happen
  // once at the pipeline entry and later stages are mode-agnostic.
  always_comb begin
    carry_in = '0;
    valid_in = '0;
    for (int k = 0; k < STAGES; k++) begin
      x_in[k]   = '0;
      y_in[k]   = '0;
      sum_in[k] = '0;
    end
    x_in[0]     = X;
    y_in[0]     = (sub == SUB) ? ~Y : Y;
    sum_in[0]   = '0;
    carry_in[0] = (sub == ADD) ? Cin : 1'b1;
    valid_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      x_in[k]     = x_q[k-1];
      y_in[k]     = y_q[k-1];
      sum_in[k]   = sum_q[k-1];
      carry_in[k] = carry_q[k-1];
      valid_in[k] = valid_q[k-1];
    end
  end

  // Stage k only ever looks at slice k of its operands.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk_a[k*CHUNK +: CHUNK] = x_in[k][k*CHUNK +: CHUNK];
      chunk_b[k*CHUNK +: CHUNK] = y_in[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .A    (chunk_a[g*CHUNK +: CHUNK]),
      .B    (chunk_b[g*CHUNK +: CHUNK]),
      .c    (carry_in[g]),
      .s    (chunk_s[g*CHUNK +: CHUNK]),
      .Cout (chunk_co[g])
    );
  end

  always_comb begin
    valid_d = valid_in;
    carry_d = chunk_co;
    for (int k = 0; k < STAGES; k++) begin
      x_d[k]                     = x_in[k];
      y_d[k]                     = y_in[k];
      sum_d[k]                   = sum_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = chunk_s[k*CHUNK +: CHUNK];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      sum_q   <= '{default: '0};
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
module tb_pipelined_chunk_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        Cin;
  logic        sub;
  logic        out_ready;
  logic [31:0] x_bus;
  logic [31:0] y_bus;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [8:0]  s_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [8:0]  s_b;
  logic        in_ready_c, out_valid_c, ovf_c;
  logic [16:0] s_c;
  logic        in_ready_d, out_valid_d, ovf_d;
  logic [32:0] s_d;

  int checks = 0;
  int passes = 0;

  pipelined_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .X(x_bus[7:0]), .Y(y_bus[7:0]), .Cin(Cin), .sub(sub),
    .out_valid(out_valid_a), .out_ready(out_ready), .s(s_a), .ovf(ovf_a));

  pipelined_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .X(x_bus[7:0]), .Y(y_bus[7:0]), .Cin(Cin), .sub(sub),
    .out_valid(out_valid_b), .out_ready(out_ready), .s(s_b), .ovf(ovf_b));

  pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .X(x_bus[15:0]), .Y(y_bus[15:0]), .Cin(Cin), .sub(sub),
    .out_valid(out_valid_c), .out_ready(out_ready), .s(s_c), .ovf(ovf_c));

  pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
    .X(x_bus), .Y(y_bus), .Cin(Cin), .sub(sub),
    .out_valid(out_valid_d), .out_ready(out_ready), .s(s_d), .ovf(ovf_d));

  // Reference: plain wide arithmetic, independent of slicing.
  function automatic logic [32:0] model_s(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic cin,
                                          input logic sb);
    logic [63:0] mask, xv, yv, full;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, x} & mask;
    yv   = sb ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    full = xv + yv + (sb ? 64'd1 : {63'd0, cin});
    full = full & ((64'd1 << (w + 1)) - 64'd1);
    return full[32:0];
  endfunction

  function automatic logic model_ovf(input int w, input logic [31:0] x,
                                     input logic [31:0] y, input logic cin,
                                     input logic sb);
    logic [63:0] mask, xv, yv, full;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, x} & mask;
    yv   = sb ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    full = xv + yv + (sb ? 64'd1 : {63'd0, cin});
    return (xv[w-1] == yv[w-1]) && (full[w-1] != xv[w-1]);
  endfunction

  task automatic run_one(input logic [7:0] x, input logic [7:0] y,
                         input logic cin, input logic sb,
                         output int lat, output logic [8:0] so, output logic ov);
    @(negedge clk);
    out_ready = 1'b1;
    x_bus     = {24'd0, x};
    y_bus     = {24'd0, y};
    Cin       = cin;
    sub       = sb;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    so = s_a;
    ov = ovf_a;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid_a);
    else passes++;
    checks++;
    if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready_a);
    else passes++;
    checks++;
    if (s_a !== 9'h000) $display("FAIL reset_s: got %h expected 000", s_a);
    else passes++;
    checks++;
    if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf_a);
    else passes++;
    checks++;
    if ({out_valid_b, out_valid_c, out_valid_d} !== 3'b000)
      $display("FAIL reset_sweep_valid: got %b expected 000", {out_valid_b, out_valid_c, out_valid_d});
    else passes++;
  endtask

  task automatic test_add();
    int lat; logic [8:0] so; logic ov;
    run_one(8'hFF, 8'h01, 1'b0, ADD, lat, so, ov);
    checks++;
    if (lat !== 4) $display("FAIL add_latency: got %0d expected 4", lat);
    else passes++;
    checks++;
    if (so !== 9'h100) $display("FAIL add_carry_s: got %h expected 100", so);
    else passes++;
    checks++;
    if (ov !== 1'b0) $display("FAIL add_carry_ovf: got %b expected 0", ov);
    else passes++;
    run_one(8'h7F, 8'h01, 1'b1, ADD, lat, so, ov);
    checks++;
    if (so !== 9'h081) $display("FAIL add_ovf_s: got %h expected 081", so);
    else passes++;
    checks++;
    if (ov !== 1'b1) $display("FAIL add_ovf_flag: got %b expected 1", ov);
    else passes++;
  endtask

  task automatic test_sub();
    int lat; logic [8:0] so; logic ov;
    run_one(8'h05, 8'h07, 1'b0, SUB, lat, so, ov);
    checks++;
    if (so !== 9'h0FE) $display("FAIL sub_borrow_s: got %h expected 0fe", so);
    else passes++;
    checks++;
    if (ov !== 1'b0) $display("FAIL sub_borrow_ovf: got %b expected 0", ov);
    else passes++;
    run_one(8'h80, 8'h01, 1'b0, SUB, lat, so, ov);
    checks++;
    if (so !== 9'h17F) $display("FAIL sub_ovf_s: got %h expected 17f", so);
    else passes++;
    checks++;
    if (ov !== 1'b1) $display("FAIL sub_ovf_flag: got %b expected 1", ov);
    else passes++;
    // Cin must be ignored in SUB mode
    run_one(8'h05, 8'h07, 1'b1, SUB, lat, so, ov);
    checks++;
    if (so !== 9'h0FE) $display("FAIL sub_ignores_cin: got %h expected 0fe", so);
    else passes++;
  endtask

  task automatic test_stream(input bit toggle, input int n);
    logic [8:0] exp_s[$];
    logic       exp_o[$];
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    bit have = 0, held_valid = 0;
    logic [8:0] held_s, es;
    logic held_o, eo;
    logic [7:0] nx, ny;
    logic nc, nsb;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held_valid) begin
        checks++;
        if (out_valid_a !== 1'b1 || s_a !== held_s || ovf_a !== held_o)
          $display("FAIL stall_hold: got v=%b s=%h o=%b expected v=1 s=%h o=%b",
                   out_valid_a, s_a, ovf_a, held_s, held_o);
        else passes++;
      end
      held_valid = 0;
      if (out_valid_a) begin
        if (out_ready) begin
          checks++;
          if (exp_s.size() == 0) begin
            $display("FAIL stream_extra: got s=%h expected no result", s_a);
          end else begin
            es = exp_s.pop_front();
            eo = exp_o.pop_front();
            if (s_a !== es || ovf_a !== eo)
              $display("FAIL stream_result: got s=%h o=%b expected s=%h o=%b", s_a, ovf_a, es, eo);
            else passes++;
          end
          got++;
          if (first < 0) first = cyc;
          last = cyc;
        end else begin
          held_valid = 1;
          held_s     = s_a;
          held_o     = ovf_a;
          checks++;
          if (in_ready_a !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready_a);
          else passes++;
        end
      end
      if (sent < n) begin
        if (!have) begin
          nx   = 8'($urandom);
          ny   = 8'($urandom);
          nc   = 1'($urandom);
          nsb  = 1'($urandom);
          have = 1;
        end
        x_bus    = {24'd0, nx};
        y_bus    = {24'd0, ny};
        Cin      = nc;
        sub      = nsb;
        in_valid = 1'b1;
        if (in_ready_a) begin
          exp_s.push_back(model_s(8, {24'd0, nx}, {24'd0, ny}, nc, nsb)[8:0]);
          exp_o.push_back(model_ovf(8, {24'd0, nx}, {24'd0, ny}, nc, nsb));
          sent++;
          have = 0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== n) $display("FAIL stream_count: got %0d expected %0d", got, n);
    else passes++;
    if (!toggle) begin
      checks++;
      if (last - first !== n - 1)
        $display("FAIL stream_contiguous: got span %0d expected %0d", last - first, n - 1);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x_bus    = 32'(i + 1);
      y_bus    = 32'(i + 2);
      Cin      = 1'b0;
      sub      = ADD;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || s_a !== 9'h000 || ovf_a !== 1'b0 || in_ready_a !== 1'b1)
      $display("FAIL midflight_reset: got v=%b s=%h o=%b r=%b expected v=0 s=000 o=0 r=1",
               out_valid_a, s_a, ovf_a, in_ready_a);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_a) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL midflight_no_output: got %b expected 0", seen);
    else passes++;
  endtask

  task automatic test_stall_reset();
    int w = 0;
    @(negedge clk);
    out_ready = 1'b0;
    x_bus     = 32'h12;
    y_bus     = 32'h34;
    Cin       = 1'b0;
    sub       = ADD;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid_a && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || s_a !== 9'h046)
      $display("FAIL stall_held_value: got v=%b s=%h expected v=1 s=046", out_valid_a, s_a);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || s_a !== 9'h000 || in_ready_a !== 1'b1)
      $display("FAIL stall_reset_clear: got v=%b s=%h r=%b expected v=0 s=000 r=1",
               out_valid_a, s_a, in_ready_a);
    else passes++;
    out_ready = 1'b1;
  endtask

  task automatic test_sweep();
    logic [31:0] vx[4], vy[4];
    logic        vc[4], vs[4];
    int la, lb, lc, ld;
    logic [8:0]  ca, cb;
    logic [16:0] cc;
    logic [32:0] cd;
    logic oa, ob, oc, od;
    vx[0] = 32'hFFFF_FFFF; vy[0] = 32'h1; vc[0] = 1'b0; vs[0] = ADD;
    vx[1] = 32'h0;         vy[1] = 32'h1; vc[1] = 1'b0; vs[1] = SUB;
    for (int i = 2; i < 4; i++) begin
      vx[i] = $urandom; vy[i] = $urandom; vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      x_bus = vx[v]; y_bus = vy[v]; Cin = vc[v]; sub = vs[v];
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      la = 0; lb = 0; lc = 0; ld = 0;
      ca = '0; cb = '0; cc = '0; cd = '0;
      oa = 0; ob = 0; oc = 0; od = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        if (out_valid_a && la == 0) begin la = cyc; ca = s_a; oa = ovf_a; end
        if (out_valid_b && lb == 0) begin lb = cyc; cb = s_b; ob = ovf_b; end
        if (out_valid_c && lc == 0) begin lc = cyc; cc = s_c; oc = ovf_c; end
        if (out_valid_d && ld == 0) begin ld = cyc; cd = s_d; od = ovf_d; end
        @(negedge clk);
      end
      checks++;
      if (la !== 4 || lb !== 1 || lc !== 4 || ld !== 4)
        $display("FAIL sweep_latency v%0d: got %0d/%0d/%0d/%0d expected 4/1/4/4", v, la, lb, lc, ld);
      else passes++;
      checks++;
      if (ca !== model_s(8, vx[v], vy[v], vc[v], vs[v])[8:0] || oa !== model_ovf(8, vx[v], vy[v], vc[v], vs[v]))
        $display("FAIL sweep_8_2 v%0d: got %h/%b expected %h/%b", v, ca, oa,
                 model_s(8, vx[v], vy[v], vc[v], vs[v])[8:0], model_ovf(8, vx[v], vy[v], vc[v], vs[v]));
      else passes++;
      checks++;
      if (cb !== model_s(8, vx[v], vy[v], vc[v], vs[v])[8:0] || ob !== model_ovf(8, vx[v], vy[v], vc[v], vs[v]))
        $display("FAIL sweep_8_8 v%0d: got %h/%b expected %h/%b", v, cb, ob,
                 model_s(8, vx[v], vy[v], vc[v], vs[v])[8:0], model_ovf(8, vx[v], vy[v], vc[v], vs[v]));
      else passes++;
      checks++;
      if (cc !== model_s(16, vx[v], vy[v], vc[v], vs[v])[16:0] || oc !== model_ovf(16, vx[v], vy[v], vc[v], vs[v]))
        $display("FAIL sweep_16_4 v%0d: got %h/%b expected %h/%b", v, cc, oc,
                 model_s(16, vx[v], vy[v], vc[v], vs[v])[16:0], model_ovf(16, vx[v], vy[v], vc[v], vs[v]));
      else passes++;
      checks++;
      if (cd !== model_s(32, vx[v], vy[v], vc[v], vs[v]) || od !== model_ovf(32, vx[v], vy[v], vc[v], vs[v]))
        $display("FAIL sweep_32_8 v%0d: got %h/%b expected %h/%b", v, cd, od,
                 model_s(32, vx[v], vy[v], vc[v], vs[v]), model_ovf(32, vx[v], vy[v], vc[v], vs[v]));
      else passes++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    Cin       = 1'b0;
    sub       = ADD;
    out_ready = 1'b0;
    x_bus     = '0;
    y_bus     = '0;
    test_reset();
    test_add();
    test_sub();
    test_stream(1'b0, 16);
    test_stream(1'b1, 16);
    test_reset_midflight();
    test_stall_reset();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_chunk_adder.md
# pipelined_chunk_adder

Parametrised, pipelined two-operand adder/subtractor that splits a WIDTH-bit addition into CHUNK-bit slices and registers one slice per stage. It is the successor to the team's fixed 8-bit adder built from chained 2-bit slices. It adds configurable width and slice size, a subtract mode, a valid/ready handshake with back-pressure, and carry/overflow flags. It sits between operand producers and any consumer needing WIDTH+1-bit results at high clock rates.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK, ≥ CHUNK
- CHUNK, 2, slice width in bits; one pipeline stage per slice
- STAGES, WIDTH/CHUNK, derived; not overridable
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and mode valid this cycle
- in_ready  out  1  block accepts an operand pair this cycle
- X  in  WIDTH  operand A
- Y  in  WIDTH  operand B
- Cin  in  1  carry-in; used in ADD mode only
- sub  in  1  0 = ADD (X+Y+Cin), 1 = SUB (X−Y)
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result this cycle
- s  out  WIDTH+1  {carry_out, sum}; in SUB mode, MSB is carry = NOT borrow
- ovf  out  1  signed (two's-complement) overflow of the WIDTH-bit result

## Operation
- Accept an operand pair when in_valid && in_ready.
- At accept time, SUB mode replaces Y with ~Y and forces slice-0 carry-in to 1. ADD mode uses Y and Cin unchanged.
- Stage k (0..STAGES−1) adds slice k of X and Y_eff plus the carry registered from stage k−1. It registers the CHUNK-bit sum and the carry-out.
- Operand slices not yet consumed travel down the pipeline in skew registers. Completed sum slices travel down in deskew registers.
- Last stage output: s = {carry_out_final, sum}. ovf = (X[MSB] == Y_eff[MSB]) && (sum[MSB] != X[MSB]). Carry the operand MSBs down the pipeline alongside the data.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry exposed in s[WIDTH].
- Per-stage valid bit. All stages advance together when global enable is set: adv = !out_valid || out_ready.
- in_ready = adv. There are no bubbles-only rules; pipeline stages carrying bubbles still advance only on adv.
- rst: all valid bits clear, s = 0, ovf = 0, and every carry/skew/sum register is 0. An in-flight operation is discarded without producing output.

## Timing
- Latency: STAGES cycles from accept edge to out_valid high, if unstalled. WIDTH=8, CHUNK=2 gives 4 cycles.
- Throughput: one result per cycle when out_ready stays high.
- Stall: while out_valid && !out_ready:
  - s, ovf and out_valid hold.
  - in_ready = 0.
  - No stage changes.
- out_valid and the data it qualifies update on the same edge.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid.
- Reset values: out_valid = 0, in_ready = 1 (after reset, since out_valid = 0), s = 0, ovf = 0.
- rst asserted while out_valid && !out_ready: all state clears on the next edge. The held result is lost.
- CHUNK == WIDTH: single stage, latency 1.

## Structure
- Shared package adder_pkg:
  - ADD = 1'b0, SUB = 1'b1 mode constants
  - a function checking that WIDTH % CHUNK == 0, used by an elaboration-time assertion
- Sub-module adder_chunk: combinational CHUNK-bit slice adder with ports A, B, c and outputs s, Cout. It is instantiated STAGES times in a generate loop.
- All registers sit in the top module.

## Test plan
- WIDTH=8, CHUNK=2, ADD: X=0xFF, Y=0x01, Cin=0 → 4 cycles later out_valid=1, s=0x100, ovf=0.
- ADD signed overflow: X=0x7F, Y=0x01, Cin=1 → s=0x081, ovf=1.
- SUB: X=0x05, Y=0x07 → s=0x0FE (carry 0 = borrow), ovf=0. Also X=0x80, Y=0x01 → s=0x17F, ovf=1.
- Back-to-back stream of 16 random pairs with out_ready=1 → 16 consecutive results, in order, matching the reference model. Repeat with out_ready toggling randomly → no loss or duplication, and s holds while stalled.
- Reset mid-flight: accept 3 pairs, assert rst for 1 cycle → out_valid stays 0, s=0, in_ready=1 the cycle after reset.
- Parameter sweep {WIDTH,CHUNK} = {8,8}, {16,4}, {32,8} → latency equals STAGES, random results match the model.
